cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache, between its physical-memory port and the burst DRAM model.
- Converts one 256-bit line request (read or write-back) into a 4-beat, 64-bit burst transaction.
- Returns a single-cycle line-level response once the burst completes.
- Cache side maps 1:1 onto pmem_address/pmem_read/pmem_write/pmem_rdata/pmem_wdata/pmem_resp.

Parameters:
- s_line, 256, line width in bits.
- s_burst, 64, burst beat width in bits.
- s_beats, s_line/s_burst (4), beats per line; must be a power of two ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- line_i  in  s_line  write-back data from cache (pmem_wdata).
- line_o  out  s_line  assembled read line to cache (pmem_rdata).
- address_i  in  32  line address from cache (pmem_address).
- read_i  in  1  line read request, held high until resp_o.
- write_i  in  1  line write request, held high until resp_o.
- resp_o  out  1  one-cycle completion pulse (pmem_resp).
- burst_i  in  s_burst  read beat from memory.
- burst_o  out  s_burst  write beat to memory.
- address_o  out  32  burst base address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, line_o=0, address_o=0, burst_o=0, read_o=0, write_o=0, resp_o=0. Mid-burst reset aborts immediately; no resp_o is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1 -> capture address_i[31:5] into address_o, with address_o[4:0] forced to 0; clear counter; go to READ.
  - else write_i=1 -> capture address_i as above and line_i into a write buffer; go to WRITE.
  - read_i and write_i both high: read wins; the write is not started.
- READ:
  - read_o=1 for the whole state.
  - On each cycle with resp_i=1: line_o[s_burst*cnt +: s_burst] <= burst_i; cnt++.
  - resp_i gaps are allowed; cnt holds through them.
  - On the beat with cnt=s_beats-1, go to DONE; read_o drops in the DONE cycle.
- WRITE:
  - write_o=1 for the whole state.
  - burst_o = buffer[s_burst*cnt +: s_burst], combinational from cnt.
  - On each resp_i=1 cycle, cnt++. On the last beat, go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0; go to IDLE unconditionally.
  - Requests are not re-sampled in DONE. The cache drops its request on the cycle after resp_o.
- line_o holds its last assembled value until the next read overwrites it. Writes never modify line_o.
- address_o and the write buffer are stable for the whole transaction; mid-transaction changes on address_i/line_i are ignored.
- resp_i while in IDLE or DONE is ignored (no state change, no capture).
- Latency with back-to-back resp_i and the first resp_i on the cycle after request capture:
  - request sampled at edge 0;
  - beats on cycles 1-4;
  - resp_o high in cycle 5.
- The counter wraps to 0 after the final beat.

Test Plan:
- Read, contiguous beats: read_i, address_i=0x0000_1234; memory drives resp_i for 4 cycles with burst_i=0x1111.., 0x2222.., 0x3333.., 0x4444.. -> address_o=0x0000_1220, read_o high through beat 4, line_o=={0x4444..,0x3333..,0x2222..,0x1111..}, resp_o one cycle, then IDLE.
- Write: line_i=256'h{D,C,B,A} (64-bit words), write_i -> write_o high; burst_o=A,B,C,D on the 4 resp_i cycles; resp_o pulses once; line_o unchanged.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; resp_o the cycle after the 7th; read_o never drops early.
- Simultaneous read_i and write_i in IDLE -> read transaction only; write_o stays 0.
- Reset mid-write: drive rst=0 after beat 2 -> write_o/read_o/resp_o go 0 asynchronously, no resp_o. After release, a new read completes normally with cnt starting at 0.
- Stray resp_i in IDLE, plus address_i changed mid-read -> no capture, no state change; address_o keeps the value latched at request.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port onto a 4-beat x 64-bit burst memory port.
// One line request becomes one burst; resp_o pulses once when the burst completes.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64,
  parameter int s_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int CNT_W = $clog2(s_beats);
  localparam logic [31:0] OFF_MASK = 32'((s_line / 8) - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_beat;
  logic [s_line-1:0]  line_q;
  logic [s_line-1:0]  wbuf_q;
  logic [31:0]        addr_q;
  logic               read_q;
  logic               write_q;
  logic               resp_q;

  // The counter is a power-of-two width, so it wraps to 0 after the last beat.
  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = (cnt_q == CNT_W'(s_beats - 1));

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign burst_o   = wbuf_q[s_burst*cnt_q +: s_burst];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          cnt_q  <= '0;
          // Read has priority when both requests arrive together.
          if (read_i) begin
            addr_q  <= address_i & ~OFF_MASK;
            read_q  <= 1'b1;
            state_q <= READ;
          end else if (write_i) begin
            addr_q  <= address_i & ~OFF_MASK;
            wbuf_q  <= line_i;
            write_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[s_burst*cnt_q +: s_burst] <= burst_i;
            cnt_q <= cnt_d;
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized directed bench for cacheline_adaptor: a line-level model predicts
// the burst beats, the assembled line and the response timing.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests = 0;
  int fails = 0;

  logic [255:0] model_line;
  logic [31:0]  model_addr;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Read transaction. npat>0 uses the first npat bits of pat as the resp_i
  // pattern; fixed drives beats 0x1111.., 0x2222.., ...
  task automatic do_read(input logic [31:0] addr, input bit also_write,
                         input int npat, input logic [15:0] pat, input bit fixed);
    int k = 0;
    int cyc = 0;
    bit r;
    logic [255:0] exp_line;
    exp_line = model_line;
    @(negedge clk);
    address_i = addr; read_i = 1'b1; write_i = also_write; resp_i = 1'b0;
    line_i = rand_line();
    @(negedge clk);
    model_addr = addr & ~32'h1F;
    chk("rd_addr", address_o, model_addr);
    chk("rd_read_o", read_o, 1);
    chk("rd_write_o", write_o, 0);
    while (k < 4) begin
      if (cyc >= 64) begin
        chk("rd_timeout", k, 4);
        break;
      end
      if (npat > 0) r = (cyc < npat) ? pat[cyc] : 1'b1;
      else r = 1'($urandom_range(0, 1));
      resp_i = r;
      burst_i = fixed ? {16{4'(k + 1)}} : {$urandom, $urandom};
      address_i = $urandom;
      if (r) begin
        exp_line[64*k +: 64] = burst_i;
        k++;
      end
      cyc++;
      @(negedge clk);
      if (k < 4) begin
        chk("rd_read_hold", read_o, 1);
        chk("rd_resp_early", resp_o, 0);
        chk("rd_write_idle", write_o, 0);
        chk("rd_addr_hold", address_o, model_addr);
      end
    end
    if (npat > 0) chk("rd_gap_cycles", cyc, npat);
    chk("rd_resp", resp_o, 1);
    chk("rd_read_drop", read_o, 0);
    chk("rd_write_o_done", write_o, 0);
    chk("rd_line", line_o, exp_line);
    chk("rd_addr_done", address_o, model_addr);
    model_line = exp_line;
    read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'($urandom_range(0, 1));
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    resp_i = 1'b0;
    chk("rd_resp_single", resp_o, 0);
    chk("rd_idle_read_o", read_o, 0);
    chk("rd_idle_line", line_o, model_line);
  endtask

  // Write transaction; abort_at>0 asserts reset once that many beats are done.
  task automatic do_write(input logic [31:0] addr, input int abort_at);
    int k = 0;
    int cyc = 0;
    bit r;
    logic [255:0] wline;
    wline = rand_line();
    @(negedge clk);
    line_i = wline; address_i = addr; write_i = 1'b1; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    model_addr = addr & ~32'h1F;
    chk("wr_addr", address_o, model_addr);
    chk("wr_write_o", write_o, 1);
    chk("wr_read_o", read_o, 0);
    while (k < 4) begin
      if (cyc >= 64) begin
        chk("wr_timeout", k, 4);
        break;
      end
      chk("wr_burst", burst_o, wline[64*k +: 64]);
      if (abort_at > 0 && k == abort_at) begin
        resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_write_o", write_o, 0);
        chk("abort_read_o", read_o, 0);
        chk("abort_resp_o", resp_o, 0);
        chk("abort_addr", address_o, 0);
        chk("abort_line", line_o, 0);
        model_line = '0;
        model_addr = '0;
        @(negedge clk);
        write_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("abort_no_resp", resp_o, 0);
          chk("abort_idle_write", write_o, 0);
        end
        return;
      end
      r = 1'($urandom_range(0, 1));
      resp_i = r;
      line_i = rand_line();
      address_i = $urandom;
      if (r) k++;
      cyc++;
      @(negedge clk);
      if (k < 4) begin
        chk("wr_write_hold", write_o, 1);
        chk("wr_resp_early", resp_o, 0);
      end
    end
    chk("wr_resp", resp_o, 1);
    chk("wr_write_drop", write_o, 0);
    chk("wr_line_untouched", line_o, model_line);
    write_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    chk("wr_resp_single", resp_o, 0);
    chk("wr_idle_write", write_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    model_line = '0;
    model_addr = '0;
    #1 rst = 1'b0;
    #11;
    chk("rst_line", line_o, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_burst", burst_o, 0);
    chk("rst_read", read_o, 0);
    chk("rst_write", write_o, 0);
    chk("rst_resp", resp_o, 0);
    @(negedge clk);
    rst = 1'b1;

    do_read(32'h0000_1234, 1'b0, 4, 16'h000F, 1'b1);
    chk("plan_addr", model_addr, 32'h0000_1220);
    chk("plan_line", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    do_write($urandom, 0);
    do_read($urandom, 1'b0, 7, 16'h0059, 1'b0);
    do_read($urandom, 1'b1, 0, 16'h0000, 1'b0);
    do_write($urandom, 2);
    do_read($urandom, 1'b0, 4, 16'h000F, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = {$urandom, $urandom}; address_i = $urandom;
      line_i = rand_line();
      @(negedge clk);
      resp_i = 1'b0;
      chk("stray_line", line_o, model_line);
      chk("stray_addr", address_o, model_addr);
      chk("stray_read", read_o, 0);
      chk("stray_write", write_o, 0);
      chk("stray_resp", resp_o, 0);
    end

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) do_read($urandom, 1'($urandom_range(0, 1)), 0, 16'h0, 1'b0);
      else do_write($urandom, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
